stumps_bist_ctrl: RTL and testbench

- Parametrised STUMPS self-test engine that replaces bench-driven test control.
- Contains an LFSR pattern generator feeding NUM_CHAINS parallel scan chains, an internal shift/capture sequencer that drives tc, and a MISR that compacts scan-chain outputs.
- Runs a fixed pattern count and compares the final signature against a golden value.
- Sits between the top-level test controller (start/abort/status) and the CUT scan chains.

---
 rtl/stumps_bist_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_stumps_bist_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stumps_bist_ctrl.sv
// STUMPS self-test engine: LFSR stimulus into NUM_CHAINS scan chains, shift/capture sequencing, MISR compaction, golden compare.
// Latency: with start sampled at edge E, done rises at edge E + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN.
// Backpressure: none; start is ignored while busy, abort (higher priority than start) returns to IDLE on the next edge.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_start, i_abort    run request (sampled in IDLE/DONE); synchronous abort
//   i_golden_sig        expected final signature
//   i_scan_out          chain outputs from the CUT (compacted by the MISR)
//   o_tc                0 = shift, 1 = functional capture
//   o_scan_en           high on shift cycles (SHIFT or FLUSH)
//   o_scan_in           chain inputs to the CUT (LFSR low bits during SHIFT, else 0)
//   o_busy, o_done      run in progress / run complete
//   o_pass              valid while done; 1 iff signature matches i_golden_sig
//   o_signature         current MISR contents
//   o_pattern_cnt       patterns captured so far
module stumps_bist_ctrl #(
  parameter int                NUM_CHAINS   = 3,
  parameter int                CHAIN_LEN    = 3,
  parameter int                NUM_PATTERNS = 12,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'h0001,
  parameter int                MISR_W       = 16,
  parameter logic [MISR_W-1:0] MISR_POLY    = 16'hB400,
  parameter int                CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [MISR_W-1:0]     i_golden_sig,
  input  logic [NUM_CHAINS-1:0] i_scan_out,
  output logic                  o_tc,
  output logic                  o_scan_en,
  output logic [NUM_CHAINS-1:0] o_scan_in,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [MISR_W-1:0]     o_signature,
  output logic [CNT_W-1:0]      o_pattern_cnt
);

  localparam int                SC_W       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [SC_W-1:0]   LAST_SHIFT = SC_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0]  NP_C       = CNT_W'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LFSR_W-1:0] r_lfsr;
  logic [MISR_W-1:0] r_misr;
  logic [SC_W-1:0]   r_shift_cnt;
  logic [CNT_W-1:0]  r_pattern_cnt;

  logic              w_start_run;
  logic              w_shift_step;
  logic              w_flush_step;
  logic              w_capture;
  logic              w_last_shift;
  logic [CNT_W-1:0]  w_pcnt_inc;
  logic [LFSR_W-1:0] w_lfsr_nxt;
  logic [MISR_W-1:0] w_misr_nxt;
  logic [MISR_W-1:0] w_scan_ext;

  assign w_last_shift = (r_shift_cnt == LAST_SHIFT);
  assign w_pcnt_inc   = r_pattern_cnt + CNT_W'(1);
  assign w_lfsr_nxt   = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_POLY)};
  assign w_misr_nxt   = {r_misr[MISR_W-2:0], ^(r_misr & MISR_POLY)} ^ w_scan_ext;

  // Zero-extend the chain outputs into MISR width (works when NUM_CHAINS == MISR_W too).
  always_comb begin
    w_scan_ext                 = '0;
    w_scan_ext[NUM_CHAINS-1:0] = i_scan_out;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_run  = 1'b0;
    w_shift_step = 1'b0;
    w_flush_step = 1'b0;
    w_capture    = 1'b0;
    o_tc         = 1'b0;
    o_scan_en    = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_SHIFT;
          w_start_run = 1'b1;
        end
      end
      S_SHIFT: begin
        o_scan_en    = 1'b1;
        o_busy       = 1'b1;
        w_shift_step = 1'b1;
        if (w_last_shift) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        o_tc      = 1'b1;
        o_busy    = 1'b1;
        w_capture = 1'b1;
        w_state_nxt = (w_pcnt_inc == NP_C) ? S_FLUSH : S_SHIFT;
      end
      S_FLUSH: begin
        o_scan_en    = 1'b1;
        o_busy       = 1'b1;
        w_flush_step = 1'b1;
        if (w_last_shift) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          w_state_nxt = S_SHIFT;
          w_start_run = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Abort beats start and freezes the datapath so signature/pattern_cnt hold.
    if (i_abort) begin
      w_state_nxt  = S_IDLE;
      w_start_run  = 1'b0;
      w_shift_step = 1'b0;
      w_flush_step = 1'b0;
      w_capture    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr        <= LFSR_SEED;
      r_misr        <= '0;
      r_shift_cnt   <= '0;
      r_pattern_cnt <= '0;
    end else if (w_start_run) begin
      r_lfsr        <= LFSR_SEED;
      r_misr        <= '0;
      r_shift_cnt   <= '0;
      r_pattern_cnt <= '0;
    end else begin
      if (i_abort) begin
        r_shift_cnt <= '0;
      end
      if (w_shift_step) begin
        r_lfsr <= w_lfsr_nxt;
        // The first load unloads uninitialised chain contents; don't compact it.
        if (r_pattern_cnt != '0) begin
          r_misr <= w_misr_nxt;
        end
      end
      if (w_flush_step) begin
        r_misr <= w_misr_nxt;
      end
      if (w_shift_step || w_flush_step) begin
        r_shift_cnt <= w_last_shift ? '0 : r_shift_cnt + SC_W'(1);
      end
      if (w_capture) begin
        r_pattern_cnt <= w_pcnt_inc;
      end
    end
  end

  assign o_scan_in     = (r_state == S_SHIFT) ? r_lfsr[NUM_CHAINS-1:0] : '0;
  assign o_pass        = o_done && (r_misr == i_golden_sig);
  assign o_signature   = r_misr;
  assign o_pattern_cnt = r_pattern_cnt;

endmodule

// File: tb/tb_stumps_bist_ctrl.sv
// Bench for stumps_bist_ctrl: three instances (4-bit/12 patterns, default, 4-bit/1 pattern) checked every cycle against a cycle-index model.
// Latency: n/a.
// Backpressure: n/a.
module tb_stumps_bist_ctrl;

  localparam int CL  = 3;
  localparam int PER = CL + 1;
  localparam int P_W    [3] = '{4, 16, 4};
  localparam int P_POLY [3] = '{32'hC, 32'hB400, 32'hC};
  localparam int P_NP   [3] = '{12, 12, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]      start_v;
  logic [2:0]      abort_v;
  logic [2:0][2:0] so_v;
  logic [3:0]      g0;
  logic [15:0]     g1;
  logic [3:0]      g2;

  wire [2:0]       ob_tc, ob_en, ob_busy, ob_done, ob_pass;
  wire [2:0][2:0]  ob_si;
  wire [2:0][15:0] ob_pcnt;
  wire [3:0]       s0_sig;
  wire [15:0]      s1_sig;
  wire [3:0]       s2_sig;
  wire [2:0][31:0] ob_sig;
  assign ob_sig[0] = {28'd0, s0_sig};
  assign ob_sig[1] = {16'd0, s1_sig};
  assign ob_sig[2] = {28'd0, s2_sig};

  stumps_bist_ctrl #(.NUM_CHAINS(3), .CHAIN_LEN(3), .NUM_PATTERNS(12), .LFSR_W(4), .LFSR_POLY(4'b1100),
                     .LFSR_SEED(4'b0001), .MISR_W(4), .MISR_POLY(4'b1100), .CNT_W(16)) u_small (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[0]), .i_abort(abort_v[0]), .i_golden_sig(g0),
    .i_scan_out(so_v[0]), .o_tc(ob_tc[0]), .o_scan_en(ob_en[0]), .o_scan_in(ob_si[0]), .o_busy(ob_busy[0]),
    .o_done(ob_done[0]), .o_pass(ob_pass[0]), .o_signature(s0_sig), .o_pattern_cnt(ob_pcnt[0]));

  stumps_bist_ctrl u_dflt (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[1]), .i_abort(abort_v[1]), .i_golden_sig(g1),
    .i_scan_out(so_v[1]), .o_tc(ob_tc[1]), .o_scan_en(ob_en[1]), .o_scan_in(ob_si[1]), .o_busy(ob_busy[1]),
    .o_done(ob_done[1]), .o_pass(ob_pass[1]), .o_signature(s1_sig), .o_pattern_cnt(ob_pcnt[1]));

  stumps_bist_ctrl #(.NUM_CHAINS(3), .CHAIN_LEN(3), .NUM_PATTERNS(1), .LFSR_W(4), .LFSR_POLY(4'b1100),
                     .LFSR_SEED(4'b0001), .MISR_W(4), .MISR_POLY(4'b1100), .CNT_W(16)) u_one (
    .i_clk(clk), .i_rst(rst), .i_start(start_v[2]), .i_abort(abort_v[2]), .i_golden_sig(g2),
    .i_scan_out(so_v[2]), .o_tc(ob_tc[2]), .o_scan_en(ob_en[2]), .o_scan_in(ob_si[2]), .o_busy(ob_busy[2]),
    .o_done(ob_done[2]), .o_pass(ob_pass[2]), .o_signature(s2_sig), .o_pattern_cnt(ob_pcnt[2]));

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endfunction

  function automatic logic [31:0] stepv(logic [31:0] v, int w, logic [31:0] poly);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return ((v << 1) | {31'd0, ^(v & poly)}) & mask;
  endfunction

  function automatic logic [31:0] gold_of(int i);
    if (i == 0) return {28'd0, g0};
    if (i == 1) return {16'd0, g1};
    return {28'd0, g2};
  endfunction

  // Model: a run is just a cycle index k since the accepted start. Cycle k
  // is a shift when k < NP*PER and k%PER < CL, a capture when k%PER == CL,
  // and a flush for the CL cycles after the last capture.
  logic [31:0] m_lfsr [3];
  logic [31:0] m_misr [3];
  logic [31:0] m_pcnt [3];
  int          m_k    [3];
  bit          m_run  [3];
  bit          m_done [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_run[i] <= 1'b0; m_done[i] <= 1'b0; m_k[i] <= 0;
        m_lfsr[i] <= 32'd1; m_misr[i] <= 32'd0; m_pcnt[i] <= 32'd0;
      end else if (abort_v[i]) begin
        m_run[i] <= 1'b0; m_done[i] <= 1'b0;
      end else if (!m_run[i] && start_v[i]) begin
        m_run[i] <= 1'b1; m_done[i] <= 1'b0; m_k[i] <= 0;
        m_lfsr[i] <= 32'd1; m_misr[i] <= 32'd0; m_pcnt[i] <= 32'd0;
      end else if (m_run[i]) begin
        if (m_k[i] < P_NP[i] * PER) begin
          if (m_k[i] % PER < CL) begin
            if (m_k[i] / PER >= 1)
              m_misr[i] <= stepv(m_misr[i], P_W[i], P_POLY[i]) ^ {29'd0, so_v[i]};
            m_lfsr[i] <= stepv(m_lfsr[i], P_W[i], P_POLY[i]);
          end else begin
            m_pcnt[i] <= m_pcnt[i] + 32'd1;
          end
        end else begin
          m_misr[i] <= stepv(m_misr[i], P_W[i], P_POLY[i]) ^ {29'd0, so_v[i]};
        end
        m_k[i] <= m_k[i] + 1;
        if (m_k[i] + 1 == P_NP[i] * PER + CL) begin
          m_run[i]  <= 1'b0;
          m_done[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit e_sh, e_cap;
      e_sh  = m_run[i] && (m_k[i] < P_NP[i] * PER) && (m_k[i] % PER < CL);
      e_cap = m_run[i] && (m_k[i] < P_NP[i] * PER) && (m_k[i] % PER == CL);
      chk($sformatf("u%0d.tc", i),        {31'd0, ob_tc[i]},   {31'd0, e_cap});
      chk($sformatf("u%0d.scan_en", i),   {31'd0, ob_en[i]},   {31'd0, m_run[i] && !e_cap});
      chk($sformatf("u%0d.busy", i),      {31'd0, ob_busy[i]}, {31'd0, m_run[i]});
      chk($sformatf("u%0d.scan_in", i),   {29'd0, ob_si[i]},   e_sh ? (m_lfsr[i] & 32'd7) : 32'd0);
      chk($sformatf("u%0d.done", i),      {31'd0, ob_done[i]}, {31'd0, m_done[i]});
      chk($sformatf("u%0d.pass", i),      {31'd0, ob_pass[i]}, {31'd0, m_done[i] && (m_misr[i] == gold_of(i))});
      chk($sformatf("u%0d.signature", i), ob_sig[i],           m_misr[i]);
      chk($sformatf("u%0d.pattern_cnt", i), {16'd0, ob_pcnt[i]}, m_pcnt[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 ns after the edge that samples start (cycle 0 of the run).
  task automatic pulse_start(int i);
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i, output int n);
    n = 0;
    while (!ob_done[i] && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("u%0d.done_within_budget", i), {31'd0, ob_done[i]}, 32'd1);
  endtask

  initial begin
    int n;
    int exp_tc [8];
    int exp_si [8];
    bit seen;
    exp_tc = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_si = '{1, 2, 4, 0, 1, 3, 6, 0};
    start_v = '0; abort_v = '0; so_v = '0;
    g0 = 4'h0; g1 = 16'h0; g2 = 4'h0;
    rst = 1'b1;
    repeat (2) tick();
    chk("reset.tc", {31'd0, ob_tc[0]}, 32'd0);
    chk("reset.busy", {31'd0, ob_busy[1]}, 32'd0);
    chk("reset.signature", ob_sig[1], 32'd0);
    rst = 1'b0;
    tick();

    // LFSR stream and tc cadence on the 4-bit configuration.
    so_v[0] = 3'b101;
    pulse_start(0);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("lfsr.tc[%0d]", j), {31'd0, ob_tc[0]}, exp_tc[j]);
      chk($sformatf("lfsr.scan_in[%0d]", j), {29'd0, ob_si[0]}, exp_si[j]);
      tick();
    end
    wait_done(0, n);
    chk("small.latency", n + 8, 32'd51);
    chk("small.pattern_cnt", {16'd0, ob_pcnt[0]}, 32'd12);

    // Default parameters, all-zero responses.
    pulse_start(1);
    wait_done(1, n);
    chk("dflt.latency", n, 32'd51);
    chk("dflt.signature", ob_sig[1], 32'd0);
    chk("dflt.pass", {31'd0, ob_pass[1]}, 32'd1);
    chk("dflt.pattern_cnt", {16'd0, ob_pcnt[1]}, 32'd12);

    // Single pattern: only the flush is compacted.
    so_v[2] = 3'b111; g2 = 4'h6;
    pulse_start(2);
    repeat (5) tick();
    chk("one.misr1", ob_sig[2], 32'h7);
    tick();
    chk("one.misr2", ob_sig[2], 32'h8);
    tick();
    chk("one.misr3", ob_sig[2], 32'h6);
    chk("one.done", {31'd0, ob_done[2]}, 32'd1);
    chk("one.pass_good", {31'd0, ob_pass[2]}, 32'd1);
    chk("one.pattern_cnt", {16'd0, ob_pcnt[2]}, 32'd1);
    g2 = 4'h5;
    #1;
    chk("one.pass_bad", {31'd0, ob_pass[2]}, 32'd0);
    g2 = 4'h6;

    // Abort with start during the 5th pattern's shift.
    pulse_start(0);
    repeat (17) tick();
    abort_v[0] = 1'b1; start_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0; start_v[0] = 1'b0;
    chk("abort.busy", {31'd0, ob_busy[0]}, 32'd0);
    chk("abort.tc", {31'd0, ob_tc[0]}, 32'd0);
    chk("abort.scan_en", {31'd0, ob_en[0]}, 32'd0);
    chk("abort.pattern_cnt", {16'd0, ob_pcnt[0]}, 32'd4);
    repeat (2) tick();
    chk("abort.stays_idle", {31'd0, ob_busy[0]}, 32'd0);
    pulse_start(0);
    chk("restart.scan_in", {29'd0, ob_si[0]}, 32'd1);
    chk("restart.pattern_cnt", {16'd0, ob_pcnt[0]}, 32'd0);
    wait_done(0, n);
    chk("restart.latency", n, 32'd51);

    // Asynchronous reset in the middle of a capture cycle.
    so_v[1] = 3'b110; g1 = 16'h1234;
    pulse_start(1);
    repeat (3) tick();
    seen = 1'b0;
    for (int j = 0; j < 10 && !seen; j++) begin
      tick();
      seen = ob_tc[1];
    end
    chk("rst.found_capture", {31'd0, seen}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst.tc", {31'd0, ob_tc[1]}, 32'd0);
    chk("rst.busy", {31'd0, ob_busy[1]}, 32'd0);
    chk("rst.signature", ob_sig[1], 32'd0);
    chk("rst.pattern_cnt", {16'd0, ob_pcnt[1]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Start pulses while busy don't stretch or restart the run.
    pulse_start(1);
    for (int j = 0; j < 3; j++) begin
      start_v[1] = 1'b1;
      tick();
      start_v[1] = 1'b0;
      tick();
    end
    wait_done(1, n);
    chk("busy_start.latency", n + 6, 32'd51);

    // Back-to-back runs from DONE reproduce the signature.
    pulse_start(2);
    wait_done(2, n);
    chk("rerun1.signature", ob_sig[2], 32'h6);
    pulse_start(2);
    wait_done(2, n);
    chk("rerun2.latency", n, 32'd7);
    chk("rerun2.signature", ob_sig[2], 32'h6);
    chk("rerun2.pass", {31'd0, ob_pass[2]}, 32'd1);
    pulse_start(1);
    wait_done(1, n);
    chk("rerun_dflt.latency", n, 32'd51);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
